// File: rtl/fu_mem_pkg.sv
// Shared encodings, request record and lane helper for the load/store unit.
// Imported by fu_mem_lsu.
package fu_mem_pkg;

  localparam logic [2:0] BHW_B  = 3'b000;
  localparam logic [2:0] BHW_H  = 3'b001;
  localparam logic [2:0] BHW_W  = 3'b010;
  localparam logic [2:0] BHW_BU = 3'b100;
  localparam logic [2:0] BHW_HU = 3'b101;

  // Tags up to this width fit in the request record; narrower tags are zero-padded.
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic                 mem_w;
    logic [2:0]           bhw;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic [TAG_MAX_W-1:0] tag;
    logic                 err;
  } lsu_req_t;

  // Shifts the addressed byte or halfword of a memory word down to bit 0.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
    logic [31:0] lane;
    case (size)
      2'b00:   lane = word >> {off, 3'b000};
      2'b01:   lane = word >> {off[1], 4'b0000};
      default: lane = word;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/mem_bank_be.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables.
// Read data updates only on enabled cycles, so dout holds while en is low.
module mem_bank_be #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   din,
  output logic [31:0]   dout
);

  logic [31:0] mem [DEPTH];

  // Read-before-write: a store's read port returns the previous word contents.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/fu_mem_lsu.sv
// Pipelined load/store unit: stage A (address/error), stage M (RAM access),
// optional delay stages, then a backpressured tagged result.
module fu_mem_lsu
  import fu_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mem_w,
  input  logic [2:0]       in_bhw,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [31:0]      in_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             out_is_store
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic             err;
    logic             is_store;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } res_t;

  logic        stall;
  logic        valid_a, valid_m;
  lsu_req_t    req_next, req_a, req_m;
  logic [31:0] eff_addr;
  logic        bad;
  logic        ram_en;
  logic [3:0]  ram_we, lane_be;
  logic [31:0] ram_din, ram_dout;
  logic [31:0] lane, load_data;
  res_t        res_m, res_out;

  // A stalled result freezes the whole pipe, including the RAM read port.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    eff_addr = in_rs1 + in_imm;
    case (in_bhw)
      BHW_B, BHW_BU: bad = 1'b0;
      BHW_H, BHW_HU: bad = eff_addr[0];
      BHW_W:         bad = (eff_addr[1:0] != 2'b00);
      default:       bad = 1'b1;
    endcase
    if (in_mem_w && in_bhw[2]) bad = 1'b1;
    req_next.mem_w = in_mem_w;
    req_next.bhw   = in_bhw;
    req_next.addr  = eff_addr;
    req_next.wdata = in_rs2;
    req_next.tag   = TAG_MAX_W'(in_tag);
    req_next.err   = bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_a <= 1'b0;
      req_a   <= '0;
    end else if (!stall) begin
      valid_a <= in_valid;
      req_a   <= req_next;
    end
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    case (req_a.bhw[1:0])
      2'b00: begin
        lane_be = 4'b0001 << req_a.addr[1:0];
        ram_din = {4{req_a.wdata[7:0]}};
      end
      2'b01: begin
        lane_be = req_a.addr[1] ? 4'b1100 : 4'b0011;
        ram_din = {2{req_a.wdata[15:0]}};
      end
      default: begin
        lane_be = 4'b1111;
        ram_din = req_a.wdata;
      end
    endcase
    ram_en = valid_a & ~req_a.err & ~stall;
    ram_we = req_a.mem_w ? lane_be : 4'b0000;
  end

  mem_bank_be #(.DEPTH(DEPTH)) u_bank (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (req_a.addr[AW+1:2]),
    .din  (ram_din),
    .dout (ram_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_m <= 1'b0;
      req_m   <= '0;
    end else if (!stall) begin
      valid_m <= valid_a;
      req_m   <= req_a;
    end
  end

  always_comb begin
    lane = lane_extract(ram_dout, req_m.bhw[1:0], req_m.addr[1:0]);
    case (req_m.bhw)
      BHW_B:   load_data = {{24{lane[7]}}, lane[7:0]};
      BHW_BU:  load_data = {24'h000000, lane[7:0]};
      BHW_H:   load_data = {{16{lane[15]}}, lane[15:0]};
      BHW_HU:  load_data = {16'h0000, lane[15:0]};
      BHW_W:   load_data = lane;
      default: load_data = '0;
    endcase
    res_m = '0;
    if (valid_m) begin
      res_m.err      = req_m.err;
      res_m.is_store = req_m.mem_w;
      res_m.tag      = req_m.tag[TAG_W-1:0];
      res_m.data     = (req_m.mem_w | req_m.err) ? 32'h0 : load_data;
    end
  end

  // With LATENCY 2 the M stage drives the outputs directly; RAM dout holds during stalls.
  generate
    if (LATENCY == 2) begin : g_direct
      assign out_valid = valid_m;
      assign res_out   = res_m;
    end else begin : g_delay
      logic [LATENCY-3:0] dly_valid;
      res_t               dly_res [LATENCY-2];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dly_valid <= '0;
          for (int i = 0; i < LATENCY-2; i++) dly_res[i] <= '0;
        end else if (!stall) begin
          dly_valid[0] <= valid_m;
          dly_res[0]   <= res_m;
          for (int i = 1; i < LATENCY-2; i++) begin
            dly_valid[i] <= dly_valid[i-1];
            dly_res[i]   <= dly_res[i-1];
          end
        end
      end

      assign out_valid = dly_valid[LATENCY-3];
      assign res_out   = dly_res[LATENCY-3];
    end
  endgenerate

  assign out_data     = res_out.data;
  assign out_tag      = res_out.tag;
  assign out_err      = res_out.err;
  assign out_is_store = res_out.is_store;

  logic unused_fields;
  assign unused_fields = ^{req_a, req_m};

endmodule

// File: tb/tb_fu_mem_lsu.sv
// Self-checking bench for fu_mem_lsu: directed scenarios plus random traffic
// scored against a byte-array memory model.
module tb_fu_mem_lsu;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
  localparam int TAG_W   = 4;
  localparam int NB      = 4 * DEPTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_mem_w;
  logic [2:0]       in_bhw;
  logic [31:0]      in_rs1, in_rs2, in_imm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready, out_err, out_is_store;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  fu_mem_lsu #(.DEPTH(DEPTH), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mem_w     (in_mem_w),
    .in_bhw       (in_bhw),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_imm       (in_imm),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_tag      (out_tag),
    .out_err      (out_err),
    .out_is_store (out_is_store)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             err;
    logic             is_store;
  } res_t;

  res_t       exp_q[$], got_q[$];
  int         acc_cyc_q[$], got_cyc_q[$];
  logic [7:0] mref [NB];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic       last_acc, s_in_ready, s_out_valid;
  res_t       s_out;

  // Architectural model: byte-addressed memory, size/alignment rules, extension.
  function automatic res_t model(input logic w, input logic [2:0] bhw,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic [TAG_W-1:0] tag);
    res_t        r;
    logic [31:0] a, v;
    int          sz;
    logic        bad;
    a = rs1 + imm;
    case (bhw)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      3'b010:         sz = 4;
      default:        sz = 0;
    endcase
    bad = (sz == 0) || (w && bhw[2]);
    if (!bad) bad = (a % sz) != 0;
    r.tag = tag;
    r.is_store = w;
    r.err = bad;
    r.data = 32'h0;
    if (!bad) begin
      if (w) begin
        for (int i = 0; i < sz; i++) mref[int'((a + 32'(i)) % NB)] = rs2[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(mref[int'((a + 32'(i)) % NB)]) << (8*i));
        if (!bhw[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
        r.data = v;
      end
    end
    return r;
  endfunction

  task automatic step();
    #1;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out       = {out_tag, out_data, out_err, out_is_store};
    last_acc    = in_valid && in_ready;
    if (last_acc) begin
      exp_q.push_back(model(in_mem_w, in_bhw, in_rs1, in_rs2, in_imm, in_tag));
      acc_cyc_q.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      got_q.push_back(s_out);
      got_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic w, input logic [2:0] bhw, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_mem_w = w;
    in_bhw   = bhw;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    in_tag   = tag;
  endtask

  task automatic issue(input logic w, input logic [2:0] bhw, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [TAG_W-1:0] tag);
    drive(w, bhw, rs1, rs2, imm, tag);
    for (int k = 0; k < 20; k++) begin
      step();
      if (last_acc) break;
    end
    checks++;
    if (!last_acc) begin
      errors++;
      $display("[TB] FAIL issue_accept: accepted=%b required=1", last_acc);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 60 && got_q.size() < exp_q.size(); k++) step();
    repeat (3) step();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL result_count: got %0d results, required %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
    acc_cyc_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 6;
    if (out_valid !== 1'b0)    begin errors++; $display("[TB] FAIL rst_out_valid: got %b required 0", out_valid); end
    if (out_data !== 32'h0)    begin errors++; $display("[TB] FAIL rst_out_data: got %h required 0", out_data); end
    if (out_tag !== '0)        begin errors++; $display("[TB] FAIL rst_out_tag: got %h required 0", out_tag); end
    if (out_err !== 1'b0)      begin errors++; $display("[TB] FAIL rst_out_err: got %b required 0", out_err); end
    if (out_is_store !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_is_store: got %b required 0", out_is_store); end
    if (in_ready !== 1'b1)     begin errors++; $display("[TB] FAIL rst_in_ready: got %b required 1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int w = 0; w < 256; w++) issue(1'b1, 3'b010, 32'(w * 4), $urandom, 32'h0, TAG_W'(w));
    drain();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks += 2;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL fill_result[%0d]: got {tag,data,err,st}=%h required %h", i, got_q[i], exp_q[i]);
      end
      if (got_cyc_q[i] - acc_cyc_q[i] != LATENCY) begin
        errors++;
        $display("[TB] FAIL fill_latency[%0d]: got %0d required %0d", i, got_cyc_q[i] - acc_cyc_q[i], LATENCY);
      end
    end
    clear_q();
  endtask

  task automatic test_store_load();
    logic        d_w   [8];
    logic [2:0]  d_bhw [8];
    logic [31:0] d_rs1 [8], d_imm [8], d_rs2 [8], d_want [8];
    d_w    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    d_bhw  = '{3'b010, 3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
    d_rs1  = '{32'h100, 32'h108, 32'h107, 32'h107, 32'h104, 32'h106, 32'h105, 32'h104};
    d_imm  = '{32'h4, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    d_rs2  = '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h11, 32'h0};
    d_want = '{32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFDE, 32'h0000_00DE,
               32'hFFFF_BEEF, 32'h0000_DEAD, 32'h0, 32'hDEAD_11EF};
    for (int i = 0; i < 8; i++) issue(d_w[i], d_bhw[i], d_rs1[i], d_rs2[i], d_imm[i], TAG_W'(i + 3));
    drain();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks += 3;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL sl_result[%0d]: got {tag,data,err,st}=%h required %h", i, got_q[i], exp_q[i]);
      end
      if (got_q[i].data !== d_want[i]) begin
        errors++;
        $display("[TB] FAIL sl_data[%0d]: got %h required %h", i, got_q[i].data, d_want[i]);
      end
      if (got_cyc_q[i] - acc_cyc_q[i] != LATENCY) begin
        errors++;
        $display("[TB] FAIL sl_latency[%0d]: got %0d required %0d", i, got_cyc_q[i] - acc_cyc_q[i], LATENCY);
      end
    end
    clear_q();
  endtask

  task automatic test_errors();
    logic        e_w   [5];
    logic [2:0]  e_bhw [5];
    logic [31:0] e_rs1 [5], e_rs2 [5];
    logic        e_err [5];
    e_w   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    e_bhw = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b010};
    e_rs1 = '{32'h103, 32'h102, 32'h100, 32'h100, 32'h100};
    e_rs2 = '{32'h0, 32'h1234_5678, 32'h0, 32'hAA, 32'h0};
    e_err = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) issue(e_w[i], e_bhw[i], e_rs1[i], e_rs2[i], 32'h0, TAG_W'(i + 9));
    drain();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks += 2;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL err_result[%0d]: got {tag,data,err,st}=%h required %h", i, got_q[i], exp_q[i]);
      end
      if (got_q[i].err !== e_err[i]) begin
        errors++;
        $display("[TB] FAIL err_flag[%0d]: got %b required %b", i, got_q[i].err, e_err[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_stall();
    int n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      out_ready = !(i >= 4 && i <= 6);
      if (n_acc < 8) drive(1'b0, 3'b010, 32'($urandom_range(0, 255) * 4), 32'h0, 32'h0, TAG_W'(n_acc));
      else in_valid = 1'b0;
      step();
      if (last_acc) n_acc++;
      if (i == 3) begin
        checks++;
        if (s_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_pre_ready: got %b required 1", s_in_ready); end
      end
      if (i >= 4 && i <= 6) begin
        checks += 3;
        if (s_in_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL stall_in_ready[%0d]: got %b required 0", i, s_in_ready);
        end
        if (s_out_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL stall_out_valid[%0d]: got %b required 1", i, s_out_valid);
        end
        if (s_out !== exp_q[got_q.size()]) begin
          errors++;
          $display("[TB] FAIL stall_hold[%0d]: got %h required %h", i, s_out, exp_q[got_q.size()]);
        end
      end
      if (n_acc == 8 && i >= 7) break;
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if (exp_q.size() != 8) begin
      errors++;
      $display("[TB] FAIL stall_accepts: got %0d required 8", exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL stall_result[%0d]: got {tag,data,err,st}=%h required %h", i, got_q[i], exp_q[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_random();
    int          n_acc = 0;
    logic        have = 1'b0;
    logic [2:0]  bhw;
    logic [31:0] a, rs1;
    for (int i = 0; i < 600 && n_acc < 60; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!have && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 5))
          0: bhw = 3'($urandom_range(0, 7));
          1: bhw = 3'b000;
          2: bhw = 3'b001;
          3: bhw = 3'b010;
          4: bhw = 3'b100;
          default: bhw = 3'b101;
        endcase
        a   = 32'($urandom_range(0, 255) * 4 + $urandom_range(0, 3)) + (32'($urandom_range(0, 15)) << 12);
        rs1 = $urandom;
        drive($urandom_range(0, 2) == 0, bhw, rs1, $urandom, a - rs1, TAG_W'($urandom));
        have = 1'b1;
      end
      if (!have) in_valid = 1'b0;
      step();
      if (last_acc) begin
        n_acc++;
        have = 1'b0;
        in_valid = 1'b0;
      end
    end
    drain();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL rand_result[%0d]: got {tag,data,err,st}=%h required %h", i, got_q[i], exp_q[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_reset_mid();
    logic [31:0] old_word;
    old_word = {mref[32'h203], mref[32'h202], mref[32'h201], mref[32'h200]};
    issue(1'b1, 3'b010, 32'h200, ~old_word, 32'h0, TAG_W'(7));
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mref[32'h200 + i] = old_word[8*i +: 8];
    clear_q();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrst_out_valid[%0d]: got %b required 0", k, out_valid);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    issue(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, TAG_W'(9));
    drain();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks += 2;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL midrst_result[%0d]: got {tag,data,err,st}=%h required %h", i, got_q[i], exp_q[i]);
      end
      if (got_q[i].data !== old_word) begin
        errors++;
        $display("[TB] FAIL midrst_old_data: got %h required %h", got_q[i].data, old_word);
      end
    end
    clear_q();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mem_w  = 1'b0;
    in_bhw    = 3'b000;
    in_rs1    = 32'h0;
    in_rs2    = 32'h0;
    in_imm    = 32'h0;
    in_tag    = '0;
    out_ready = 1'b1;
    $display("[TB] starting fu_mem_lsu bench");
    test_reset();
    test_fill();
    test_store_load();
    test_errors();
    test_stall();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fu_mem_lsu.md
# fu_mem_lsu

Pipelined, parametrised load/store functional unit for the out-of-order core. It accepts one memory micro-op per cycle over a valid/ready handshake and computes the effective address rs1+imm. It performs byte/half/word loads (sign- or zero-extended) and stores against an internal byte-enabled data memory. It returns a tagged result after a fixed LATENCY, with misalignment reporting and output backpressure. It replaces the single-outstanding, fixed-latency memory unit in the execute stage.

## Interface
- DEPTH, 1024: number of 32-bit memory words; power of two, ≥4.
- LATENCY, 2: cycles from accept to out_valid with no stalls; ≥2.
- TAG_W, 4: width of the issue tag carried through to the result.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept; = ~(out_valid & ~out_ready).
- in_mem_w  in  1  1 = store, 0 = load.
- in_bhw  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others reserved.
- in_rs1, in_rs2, in_imm  in  32 each  base, store data, offset.
- in_tag  in  TAG_W  issue tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  32  extended load data; 0 for stores and errors.
- out_tag  out  TAG_W  tag of result.
- out_err  out  1  misaligned or reserved bhw; memory untouched.
- out_is_store  out  1  result belongs to a store.

## Operation
- Accept: in_valid & in_ready at a rising edge.
- Address: addr = in_rs1 + in_imm, mod 2^32. Word index = addr[log2(DEPTH)+1:2]. Upper bits ignored, so accesses wrap.
- Error conditions: H/HU with addr[0]=1; W with addr[1:0]≠0; any reserved bhw. On error: no read or write, out_err=1, out_data=0.
- Stores: SB writes rs2[7:0] to lane addr[1:0]. SH writes rs2[15:0] to lanes {addr[1],0} and {addr[1],1}. SW writes all lanes. Other lanes are unchanged. Stores use bhw[1:0]; bhw[2]=1 with a store is reserved.
- Loads: lane select uses the same rule as stores. B/H sign-extend; BU/HU zero-extend; W passes through.
- Ordering: strictly in order, one memory access per request. Memory read/write occurs exactly once, on the edge where a request advances from stage A to stage M.
- Stall: while out_valid & ~out_ready, every stage holds, RAM read enable is low (dout holds), and in_ready=0.
- Reset values: all stage valids 0, out_valid 0, out_data 0, out_tag 0, out_err 0, out_is_store 0. Memory contents are not reset.
- Reset mid-operation: all in-flight requests are discarded with no result. A store already written stays written. A store still in stage A is never written.

## Timing
- Pipeline: A (request registered, addr and err computed) → M (synchronous RAM access) → LATENCY-2 delay stages → output.
- Request accepted at edge ending cycle c → out_valid in cycle c+LATENCY, absent stalls. Each stall cycle adds one cycle.
- Throughput: 1 request/cycle.
- Store write timing: a store accepted in cycle c writes at the edge ending c+1.
- Back-to-back store→load to the same word returns the new data. The load reads one edge after the store's write; no bypass is needed.
- Simultaneous out_valid&out_ready and in_valid: both transfers happen in the same cycle and the pipeline advances.
- out_* are stable while out_valid & ~out_ready.

## Structure
- Package fu_mem_pkg holds:
  - bhw encodings as localparams: BHW_B, BHW_H, BHW_W, BHW_BU, BHW_HU;
  - a request struct {mem_w, bhw, addr, wdata, tag, err};
  - the lane-extract function.
- One sub-module, mem_bank_be: single-port synchronous RAM with DEPTH×32 and a 4-bit byte write enable. It registers read data only when en=1.
- The top module holds the stage registers, the stall logic and the extension logic.

## Test plan
- SW rs1=0x100, imm=4, rs2=0xDEADBEEF, then LW 0x104 → store result: out_is_store=1, data 0. Load result: out_data=0xDEADBEEF, tags preserved, out_valid exactly LATENCY cycles after each accept.
- With word 0x104=0xDEADBEEF: LB 0x107 → 0xFFFFFFDE; LBU 0x107 → 0x000000DE; LH 0x104 → 0xFFFFBEEF; LHU 0x106 → 0x0000DEAD.
- SB 0x105 rs2=0x11 then LW 0x104 in the next cycle → 0xDEAD11EF, proving once-only write ordering without bypass.
- LH 0x103, SW 0x102, bhw=011 → out_err=1, out_data=0. A following LW 0x100 shows memory is unchanged.
- Stream 8 back-to-back loads while out_ready is held low 3 cycles mid-stream → in_ready=0 during the stall, no result lost or duplicated, tags in order.
- Accept SW 0x200 then pulse rst_n low in the next cycle → no out_valid after reset. LW 0x200 shows the old data, since the store was still in stage A.
